mem_access_unit: RTL and testbench

Initiator side of the data-memory port: it sits in the MEM stage between the pipeline and the word-addressed, single-port data memory (combinational read, clocked write-enable). It accepts byte-addressed load/store requests of byte, halfword or word size and sequences word-level reads and writes to the memory. Sub-word stores are done as read-modify-write. Loads are zero- or sign-extended. Misaligned or illegal requests complete with an error and never touch memory.

---
 rtl/mem_access_pkg.sv | 25 ++
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // True when the request can never reach memory: illegal size or a lane crossing a word.
    function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: req_misaligned = 1'b0;
            SZ_HALF: req_misaligned = addr_lo[0];
            SZ_WORD: req_misaligned = (addr_lo != 2'b00);
            default: req_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle of the MEM-stage memory access unit.
interface mem_access_unit_if #(
    parameter int AW = 7
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_error;
    logic [31:0]   rsp_rdata;
    logic          busy;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_error, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_error, rsp_rdata, busy
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store merge into an old word and load extraction/extension.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] merged,
    output logic [31:0] load_val
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane8;
    logic [15:0] lane16;

    assign byte_sh = {addr_lo, 3'b000};
    assign half_sh = {addr_lo[1], 4'b0000};
    assign lane8   = old_word[byte_sh +: 8];
    assign lane16  = old_word[half_sh +: 16];

    always_comb begin
        merged   = store_data;
        load_val = old_word;
        case (size)
            SZ_BYTE: begin
                merged                = old_word;
                merged[byte_sh +: 8]  = store_data[7:0];
                load_val              = {{24{is_signed & lane8[7]}}, lane8};
            end
            SZ_HALF: begin
                merged                = old_word;
                merged[half_sh +: 16] = store_data[15:0];
                load_val              = {{16{is_signed & lane16[15]}}, lane16};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: sequences byte/half/word loads and stores onto a word-addressed
// single-port memory, with read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int WORD_LEN = 32,
    parameter int AW       = $clog2(WIDTH) + 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_access_unit_if.slave    bus,
    output logic                mem_write,
    output logic [AW-3:0]       mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic          signed_q, signed_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          error_q, error_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic [31:0]   merged;
    logic [31:0]   load_val;

    mem_lane_align u_align (
        .size       (size_q),
        .addr_lo    (addr_q[1:0]),
        .is_signed  (signed_q),
        .old_word   (mem_rdata),
        .store_data (wdata_q),
        .merged     (merged),
        .load_val   (load_val)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        signed_d    = signed_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    signed_d = bus.req_signed;
                    size_d   = bus.req_size;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (req_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        error_d = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                        // Full-word stores skip the read and write the data untouched.
                        mem_wdata_d = bus.req_wdata;
                        state_d     = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    mem_wdata_d = merged;
                    state_d     = WRITE;
                end else begin
                    rdata_d = load_val;
                    error_d = 1'b0;
                    state_d = RESP;
                end
            end
            WRITE: begin
                rdata_d = '0;
                error_d = 1'b0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= SZ_BYTE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            signed_q    <= signed_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Write enable comes straight from the state so an async reset drops it at once.
    assign mem_write     = (state_q == WRITE);
    assign mem_addr      = addr_q[AW-1:2];
    assign mem_wdata     = mem_wdata_q;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_error = error_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int WIDTH = 32;
    localparam int AW    = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.AW(AW)) bus ();

    logic          mem_write;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem [WIDTH];

    logic          pre_we   = 1'b0;
    logic [AW-3:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;

    int n_cmp    = 0;
    int n_fail   = 0;
    int wr_rises = 0;

    mem_access_unit #(.WIDTH(WIDTH), .WORD_LEN(32), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write)   mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    always @(posedge mem_write) wr_rises++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-3:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Issue one request from IDLE, wait (bounded) for its response, then step back to IDLE.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [AW-1:0] a, input logic [31:0] wd,
                           output int lat, output int nwr, output logic err,
                           output logic [31:0] rd, output logic rv_after);
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
        lat = 1;
        nwr = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 8) begin
            if (mem_write === 1'b1) nwr++;
            tick();
            lat++;
        end
        err = bus.rsp_error;
        rd  = bus.rsp_rdata;
        tick();
        rv_after = bus.rsp_valid;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got valid=%b err=%b want 0 0", bus.rsp_valid, bus.rsp_error); end
        n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata); end
        n_cmp++; if (mem_write !== 1'b0 || mem_addr !== 5'd0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem: got we=%b addr=%h wd=%h want 0 0 0", mem_write, mem_addr, mem_wdata); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_word();
        int lat, nwr; logic err, rv; logic [31:0] rd;
        run_req(1'b1, SZ_WORD, 1'b0, 7'h14, 32'hDEADBEEF, lat, nwr, err, rd, rv);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL word_st_lat: got %0d want 2", lat); end
        n_cmp++; if (nwr !== 1 || err !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL word_st_rsp: got nwr=%0d err=%b rd=%h want 1 0 0", nwr, err, rd); end
        n_cmp++; if (mem[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_st_mem: got %h want deadbeef", mem[5]); end
        n_cmp++; if (rv !== 1'b0) begin n_fail++; $display("FAIL word_st_pulse: got %b want 0", rv); end
        run_req(1'b0, SZ_WORD, 1'b0, 7'h14, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL word_ld_lat: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF || err !== 1'b0 || nwr !== 0) begin n_fail++; $display("FAIL word_ld: got rd=%h err=%b nwr=%0d want deadbeef 0 0", rd, err, nwr); end
    endtask

    task automatic test_byte();
        int lat, nwr; logic err, rv; logic [31:0] rd;
        preload(5'd5, 32'h11223344);
        run_req(1'b1, SZ_BYTE, 1'b0, 7'h15, 32'h123456AA, lat, nwr, err, rd, rv);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL byte_st_lat: got %0d want 3", lat); end
        n_cmp++; if (nwr !== 1) begin n_fail++; $display("FAIL byte_st_we: got %0d cycles want 1", nwr); end
        n_cmp++; if (mem[5] !== 32'h1122AA44) begin n_fail++; $display("FAIL byte_st_mem: got %h want 1122aa44", mem[5]); end
        run_req(1'b0, SZ_BYTE, 1'b1, 7'h15, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (rd !== 32'hFFFFFFAA || lat !== 2) begin n_fail++; $display("FAIL byte_ld_s: got %h lat %0d want ffffffaa lat 2", rd, lat); end
        run_req(1'b0, SZ_BYTE, 1'b0, 7'h15, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (rd !== 32'h000000AA) begin n_fail++; $display("FAIL byte_ld_u: got %h want 000000aa", rd); end
        run_req(1'b0, SZ_BYTE, 1'b0, 7'h14, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (rd !== 32'h00000044) begin n_fail++; $display("FAIL byte_ld_lane0: got %h want 00000044", rd); end
        run_req(1'b0, SZ_BYTE, 1'b1, 7'h17, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (rd !== 32'h00000011) begin n_fail++; $display("FAIL byte_ld_lane3: got %h want 00000011", rd); end
    endtask

    task automatic test_half();
        int lat, nwr; logic err, rv; logic [31:0] rd;
        run_req(1'b1, SZ_HALF, 1'b0, 7'h16, 32'h12348001, lat, nwr, err, rd, rv);
        n_cmp++; if (lat !== 3 || nwr !== 1) begin n_fail++; $display("FAIL half_st_timing: got lat %0d we %0d want 3 1", lat, nwr); end
        n_cmp++; if (mem[5] !== 32'h8001AA44) begin n_fail++; $display("FAIL half_st_mem: got %h want 8001aa44", mem[5]); end
        run_req(1'b0, SZ_HALF, 1'b1, 7'h16, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL half_ld_s: got %h want ffff8001", rd); end
        run_req(1'b0, SZ_HALF, 1'b0, 7'h16, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL half_ld_u: got %h want 00008001", rd); end
        run_req(1'b0, SZ_HALF, 1'b1, 7'h14, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (rd !== 32'hFFFFAA44) begin n_fail++; $display("FAIL half_ld_lo: got %h want ffffaa44", rd); end
    endtask

    task automatic test_errors();
        int lat, nwr, w0; logic err, rv; logic [31:0] rd;
        w0 = wr_rises;
        run_req(1'b0, SZ_WORD, 1'b0, 7'h06, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_word: got lat %0d err %b rd %h want 1 1 0", lat, err, rd); end
        run_req(1'b0, 2'b11, 1'b0, 7'h14, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_size: got lat %0d err %b rd %h want 1 1 0", lat, err, rd); end
        run_req(1'b1, SZ_HALF, 1'b0, 7'h03, 32'hFFFF, lat, nwr, err, rd, rv);
        n_cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_half: got lat %0d err %b rd %h want 1 1 0", lat, err, rd); end
        n_cmp++; if (wr_rises !== w0) begin n_fail++; $display("FAIL err_nowrite: got %0d write pulses want 0", wr_rises - w0); end
        run_req(1'b0, SZ_WORD, 1'b0, 7'h14, 32'h0, lat, nwr, err, rd, rv);
        n_cmp++; if (err !== 1'b0 || rd !== 32'h8001AA44) begin n_fail++; $display("FAIL err_clear: got err %b rd %h want 0 8001aa44", err, rd); end
    endtask

    task automatic test_back_to_back();
        int lat, bad; logic [31:0] rd;
        bus.req_write  = 1'b0;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = 7'h14;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_size   = SZ_HALF;
        bus.req_addr   = 7'h16;
        lat = 1;
        bad = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 8) begin
            if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
            tick();
            lat++;
        end
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
        rd = bus.rsp_rdata;
        n_cmp++; if (lat !== 2 || rd !== 32'h8001AA44) begin n_fail++; $display("FAIL b2b_first: got lat %0d rd %h want 2 8001aa44", lat, rd); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_stall: got %0d bad cycles want 0", bad); end
        tick();
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got ready %b busy %b valid %b want 1 0 0", bus.req_ready, bus.busy, bus.rsp_valid); end
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        rd = bus.rsp_rdata;
        n_cmp++; if (lat !== 2 || rd !== 32'h00008001) begin n_fail++; $display("FAIL b2b_second: got lat %0d rd %h want 2 00008001", lat, rd); end
        tick();
    endtask

    task automatic test_reset_mid();
        int w0, nrv; logic [31:0] saved;
        w0    = wr_rises;
        saved = mem[5];
        nrv   = 0;
        bus.req_write  = 1'b1;
        bus.req_size   = SZ_BYTE;
        bus.req_signed = 1'b0;
        bus.req_addr   = 7'h14;
        bus.req_wdata  = 32'h55;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL rmid_read: got busy %b we %b want 1 0", bus.busy, mem_write); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl: got ready %b busy %b valid %b err %b want 1 0 0 0", bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_error); end
        n_cmp++; if (bus.rsp_rdata !== 32'h0 || mem_write !== 1'b0 || mem_addr !== 5'd0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rmid_data: got rd %h we %b addr %h wd %h want 0 0 0 0", bus.rsp_rdata, mem_write, mem_addr, mem_wdata); end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b0) nrv++;
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b0) nrv++;
        end
        n_cmp++; if (nrv !== 0) begin n_fail++; $display("FAIL rmid_norsp: got %0d valid cycles want 0", nrv); end
        n_cmp++; if (wr_rises !== w0 || mem[5] !== saved) begin n_fail++; $display("FAIL rmid_mem: got %0d writes word5 %h want 0 %h", wr_rises - w0, mem[5], saved); end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
